// File: rtl/mem_stage_pkg.sv
// Shared defaults and FSM state encoding for the memory stage.
// Optional request timeout is enabled by defining MEM_TIMEOUT_EN.
package mem_stage_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int REG_W_DEF      = 4;
    localparam int TMO_CYCLES_DEF = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Memory access sequencer: tracks the outstanding request, drives req/stall.
// With MEM_TIMEOUT_EN defined, an unacknowledged access is abandoned after TMO_CYCLES.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic mem_ack_i,
    output logic mem_req_o,
    output logic stall_o,
    output logic tmo_o
`ifdef MEM_TIMEOUT_EN
    ,
    output logic err_o
`endif
);

    mem_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // tmo_o fires in the last permitted wait cycle so the abandon happens on its edge
    always_comb begin
        tmo_o = (state_q == ACCESS) && !mem_ack_i && (cnt_q == CNT_W'(TMO_CYCLES - 1));
        cnt_d = '0;
        if ((state_q == ACCESS) && !mem_ack_i && !tmo_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = err_q | tmo_o;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign tmo_o = 1'b0;
`endif

    // A new op can only be captured while not stalled, i.e. from IDLE or on the ack edge
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = ACCESS;
        end else if ((state_q == ACCESS) && (mem_ack_i || tmo_o)) begin
            state_d = IDLE;
        end
    end

    assign mem_req_o = (state_q == ACCESS);
    assign stall_o   = (state_q == ACCESS) && !mem_ack_i;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register A, MEM/WB register B, forwarding outputs.
// Define MEM_TIMEOUT_EN to add the access timeout and the sticky err_o output.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_W      = REG_W_DEF,
    parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] alures_i,
    input  logic [DATA_W-1:0] alusrc2_i,
    input  logic [REG_W-1:0]  regdst_i,
    input  logic              regwrite_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [REG_W-1:0]  exregdst_o,
    output logic              exregwrite_o,
    output logic [DATA_W-1:0] exregdata_o,
    output logic [REG_W-1:0]  memregdst_o,
    output logic              memregwrite_o,
    output logic [DATA_W-1:0] memregdata_o
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              err_o
`endif
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alures;
        logic [DATA_W-1:0] alusrc2;
        logic [REG_W-1:0]  regdst;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
    } stage_a_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_W-1:0]  regdst;
        logic [DATA_W-1:0] data;
    } stage_b_t;

    stage_a_t a_p1_q, a_p1_d;
    stage_b_t b_p2_q, b_p2_d;
    logic     stall;
    logic     tmo;
    logic     start;

    assign start = !stall && valid_i && (memread_i || memwrite_i);

    mem_access_fsm #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .mem_ack_i (mem_ack_i),
        .mem_req_o (mem_req_o),
        .stall_o   (stall),
        .tmo_o     (tmo)
`ifdef MEM_TIMEOUT_EN
        ,
        .err_o     (err_o)
`endif
    );

    // EX/MEM boundary; an abandoned access is killed so it never reaches writeback
    always_comb begin
        a_p1_d = a_p1_q;
        if (!stall) begin
            a_p1_d.valid    = valid_i;
            a_p1_d.alures   = alures_i;
            a_p1_d.alusrc2  = alusrc2_i;
            a_p1_d.regdst   = regdst_i;
            a_p1_d.regwrite = regwrite_i;
            a_p1_d.memread  = memread_i;
            a_p1_d.memwrite = memwrite_i;
        end
        if (tmo) begin
            a_p1_d.valid = 1'b0;
        end
    end

    // MEM/WB boundary; stores never write a register
    always_comb begin
        b_p2_d.valid    = a_p1_q.valid;
        b_p2_d.regwrite = a_p1_q.regwrite && !a_p1_q.memwrite;
        b_p2_d.regdst   = a_p1_q.regdst;
        b_p2_d.data     = a_p1_q.memread ? mem_rdata_i : a_p1_q.alures;
        if (stall) begin
            b_p2_d.valid    = 1'b0;
            b_p2_d.regwrite = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_p1_q <= '0;
            b_p2_q <= '0;
        end else begin
            a_p1_q <= a_p1_d;
            b_p2_q <= b_p2_d;
        end
    end

    assign stall_o       = stall;
    assign mem_we_o      = a_p1_q.memwrite;
    assign mem_addr_o    = a_p1_q.alures;
    assign mem_wdata_o   = a_p1_q.alusrc2;

    assign exregdst_o    = a_p1_q.regdst;
    assign exregwrite_o  = a_p1_q.valid && a_p1_q.regwrite && !a_p1_q.memread;
    assign exregdata_o   = a_p1_q.alures;

    assign memregdst_o   = b_p2_q.regdst;
    assign memregwrite_o = b_p2_q.valid && b_p2_q.regwrite;
    assign memregdata_o  = b_p2_q.data;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks are queued at issue and popped at MEM/WB.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              clk;
    logic              rst;
    logic              valid_i;
    logic [DATA_W-1:0] alures_i;
    logic [DATA_W-1:0] alusrc2_i;
    logic [REG_W-1:0]  regdst_i;
    logic              regwrite_i;
    logic              memread_i;
    logic              memwrite_i;
    logic              stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic [REG_W-1:0]  exregdst_o;
    logic              exregwrite_o;
    logic [DATA_W-1:0] exregdata_o;
    logic [REG_W-1:0]  memregdst_o;
    logic              memregwrite_o;
    logic [DATA_W-1:0] memregdata_o;
`ifdef MEM_TIMEOUT_EN
    logic              err_o;
`endif

    int checks_total  = 0;
    int checks_passed = 0;
    logic [REG_W+DATA_W-1:0] exp_q[$];

    mem_stage #(
        .DATA_W     (DATA_W),
        .REG_W      (REG_W),
        .TMO_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .alures_i      (alures_i),
        .alusrc2_i     (alusrc2_i),
        .regdst_i      (regdst_i),
        .regwrite_i    (regwrite_i),
        .memread_i     (memread_i),
        .memwrite_i    (memwrite_i),
        .stall_o       (stall_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ack_i     (mem_ack_i),
        .exregdst_o    (exregdst_o),
        .exregwrite_o  (exregwrite_o),
        .exregdata_o   (exregdata_o),
        .memregdst_o   (memregdst_o),
        .memregwrite_o (memregwrite_o),
        .memregdata_o  (memregdata_o)
`ifdef MEM_TIMEOUT_EN
        ,
        .err_o         (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Writeback monitor: every MEM/WB write must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && memregwrite_o === 1'b1) begin
            logic [REG_W+DATA_W-1:0] e;
            checks_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected got dst=%0d data=%h required no writeback",
                         memregdst_o, memregdata_o);
            end else begin
                e = exp_q.pop_front();
                if ({memregdst_o, memregdata_o} !== e)
                    $display("FAIL wb_data got dst=%0d data=%h required dst=%0d data=%h",
                             memregdst_o, memregdata_o, e[REG_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                else
                    checks_passed++;
            end
        end
    end

    task automatic drive_idle();
        valid_i    = 1'b0;
        alures_i   = '0;
        alusrc2_i  = '0;
        regdst_i   = '0;
        regwrite_i = 1'b0;
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic rw,
                            input logic [REG_W-1:0] dst, input logic [DATA_W-1:0] res,
                            input logic [DATA_W-1:0] src2);
        valid_i    = 1'b1;
        memread_i  = rd;
        memwrite_i = wr;
        regwrite_i = rw;
        regdst_i   = dst;
        alures_i   = res;
        alusrc2_i  = src2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        #2 rst = 1'b0;
        #1;
        checks_total++; if (stall_o !== 1'b0) $display("FAIL rst_stall got %b required 0", stall_o); else checks_passed++;
        checks_total++; if (mem_req_o !== 1'b0) $display("FAIL rst_req got %b required 0", mem_req_o); else checks_passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks_total++; if ({exregwrite_o, memregwrite_o, mem_we_o} !== 3'b000)
            $display("FAIL rst_we got %b required 000", {exregwrite_o, memregwrite_o, mem_we_o}); else checks_passed++;
        checks_total++; if ({exregdata_o, memregdata_o, memregdst_o} !== '0)
            $display("FAIL rst_data got %h/%h/%0d required 0", exregdata_o, memregdata_o, memregdst_o); else checks_passed++;
`ifdef MEM_TIMEOUT_EN
        checks_total++; if (err_o !== 1'b0) $display("FAIL rst_err got %b required 0", err_o); else checks_passed++;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_alu();
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b1, 4'd5, 16'h1234, 16'h0000);
        exp_q.push_back({4'd5, 16'h1234});
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks_total++; if ({exregdst_o, exregwrite_o, exregdata_o} !== {4'd5, 1'b1, 16'h1234})
            $display("FAIL alu_fwd got dst=%0d we=%b data=%h required 5/1/1234", exregdst_o, exregwrite_o, exregdata_o);
        else checks_passed++;
        @(posedge clk);
        @(negedge clk);
        checks_total++; if (memregwrite_o !== 1'b1) $display("FAIL alu_wb_en got %b required 1", memregwrite_o); else checks_passed++;
    endtask

    task automatic test_zero_wait_load();
        int stalls = 0;
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 4'd3, 16'h0040, 16'h0000);
        exp_q.push_back({4'd3, 16'hBEEF});
        @(posedge clk); #1;
        drive_idle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'hBEEF;
        @(negedge clk);
        if (stall_o === 1'b1) stalls++;
        checks_total++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 16'h0040})
            $display("FAIL zw_req got req=%b we=%b addr=%h required 1/0/0040", mem_req_o, mem_we_o, mem_addr_o); else checks_passed++;
        checks_total++; if (exregwrite_o !== 1'b0) $display("FAIL zw_nofwd got %b required 0", exregwrite_o); else checks_passed++;
        @(posedge clk); #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        @(negedge clk);
        if (stall_o === 1'b1) stalls++;
        checks_total++; if (stalls != 0) $display("FAIL zw_stall got %0d stall cycles required 0", stalls); else checks_passed++;
        checks_total++; if (mem_req_o !== 1'b0) $display("FAIL zw_idle got req=%b required 0", mem_req_o); else checks_passed++;
    endtask

    task automatic test_wait_load();
        int stalls = 0;
        int bad_addr = 0;
        int wb = 0;
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 4'd7, 16'h0040, 16'h0000);
        exp_q.push_back({4'd7, 16'hCAFE});
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall_o === 1'b1) stalls++;
            if (mem_addr_o !== 16'h0040) bad_addr++;
            if (memregwrite_o !== 1'b0) wb++;
            @(posedge clk); #1;
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'hCAFE;
        @(negedge clk);
        if (stall_o === 1'b1) stalls++;
        if (mem_addr_o !== 16'h0040) bad_addr++;
        checks_total++; if (stalls != 3) $display("FAIL wl_stall got %0d cycles required 3", stalls); else checks_passed++;
        checks_total++; if (bad_addr != 0) $display("FAIL wl_addr got %0d unstable cycles required 0", bad_addr); else checks_passed++;
        checks_total++; if (wb != 0) $display("FAIL wl_bubble got %0d writes required 0", wb); else checks_passed++;
        @(posedge clk); #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        @(negedge clk);
        checks_total++; if (memregwrite_o !== 1'b1) $display("FAIL wl_wb_en got %b required 1", memregwrite_o); else checks_passed++;
    endtask

    task automatic test_store();
        @(posedge clk); #1;
        drive_op(1'b0, 1'b1, 1'b1, 4'd9, 16'h0010, 16'h00AA);
        @(posedge clk); #1;
        drive_idle();
        mem_ack_i = 1'b1;
        @(negedge clk);
        checks_total++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 16'h0010, 16'h00AA})
            $display("FAIL st_bus got req=%b we=%b addr=%h wdata=%h required 1/1/0010/00AA",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); else checks_passed++;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        checks_total++; if (memregwrite_o !== 1'b0) $display("FAIL st_nowb got %b required 0", memregwrite_o); else checks_passed++;
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 4'd1, 16'h0100, 16'h0000);
        exp_q.push_back({4'd1, 16'h1111});
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 4'd2, 16'h0200, 16'h0000);
        exp_q.push_back({4'd2, 16'h2222});
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h1111;
        @(negedge clk);
        checks_total++; if ({stall_o, mem_addr_o} !== {1'b0, 16'h0100})
            $display("FAIL b2b_first got stall=%b addr=%h required 0/0100", stall_o, mem_addr_o); else checks_passed++;
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b1, 4'd4, 16'h3333, 16'h0000);
        exp_q.push_back({4'd4, 16'h3333});
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        @(negedge clk);
        checks_total++; if ({mem_req_o, stall_o, mem_addr_o} !== {1'b1, 1'b1, 16'h0200})
            $display("FAIL b2b_second got req=%b stall=%b addr=%h required 1/1/0200", mem_req_o, stall_o, mem_addr_o); else checks_passed++;
        @(posedge clk); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h2222;
        @(negedge clk);
        checks_total++; if (stall_o !== 1'b0) $display("FAIL b2b_ack got stall=%b required 0", stall_o); else checks_passed++;
        @(posedge clk); #1;
        drive_idle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        @(negedge clk);
        checks_total++; if ({mem_req_o, exregwrite_o, exregdata_o} !== {1'b0, 1'b1, 16'h3333})
            $display("FAIL b2b_alu got req=%b fwd=%b data=%h required 0/1/3333", mem_req_o, exregwrite_o, exregdata_o); else checks_passed++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 4'd6, 16'h0050, 16'h0000);
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b1, 4'd8, 16'h5555, 16'h0000);
        @(posedge clk); #3;
        checks_total++; if ({mem_req_o, stall_o} !== 2'b11)
            $display("FAIL rma_pre got req=%b stall=%b required 1/1", mem_req_o, stall_o); else checks_passed++;
        rst = 1'b0;
        #1;
        checks_total++; if ({mem_req_o, stall_o, mem_we_o, exregwrite_o, memregwrite_o} !== 5'b00000)
            $display("FAIL rma_async got req/stall/we/exwe/memwe=%b required 00000",
                     {mem_req_o, stall_o, mem_we_o, exregwrite_o, memregwrite_o}); else checks_passed++;
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks_total++; if ({mem_req_o, stall_o} !== 2'b00)
            $display("FAIL rma_idle got req=%b stall=%b required 0/0", mem_req_o, stall_o); else checks_passed++;
    endtask

    task automatic test_timeout();
        int stalls = 0;
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 4'd6, 16'h0060, 16'h0000);
`ifndef MEM_TIMEOUT_EN
        exp_q.push_back({4'd6, 16'h7777});
`endif
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (stall_o === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        checks_total++; if (stalls != 16) $display("FAIL tmo_wait got %0d stall cycles required 16", stalls); else checks_passed++;
        @(negedge clk);
`ifdef MEM_TIMEOUT_EN
        checks_total++; if ({stall_o, mem_req_o, err_o, memregwrite_o} !== 4'b0010)
            $display("FAIL tmo_abort got stall=%b req=%b err=%b wb=%b required 0/0/1/0",
                     stall_o, mem_req_o, err_o, memregwrite_o); else checks_passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks_total++; if ({err_o, memregwrite_o} !== 2'b10)
            $display("FAIL tmo_sticky got err=%b wb=%b required 1/0", err_o, memregwrite_o); else checks_passed++;
`else
        checks_total++; if ({stall_o, mem_req_o} !== 2'b11)
            $display("FAIL notmo_hold got stall=%b req=%b required 1/1", stall_o, mem_req_o); else checks_passed++;
        @(posedge clk); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h7777;
        @(posedge clk); #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        @(negedge clk);
        checks_total++; if (memregwrite_o !== 1'b1) $display("FAIL notmo_wb got %b required 1", memregwrite_o); else checks_passed++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_zero_wait_load();
        test_wait_load();
        test_store();
        test_back_to_back();
        test_reset_mid_access();
        test_timeout();
        repeat (3) @(posedge clk);
        checks_total++;
        if (exp_q.size() != 0) $display("FAIL sb_drain got %0d pending required 0", exp_q.size());
        else checks_passed++;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
